// File: rtl/tile_renderer_pkg.sv
// Shared types and constants for the tile-grid pixel generator.
package tile_renderer_pkg;

    localparam logic [7:0] BLK = 8'h00;
    localparam logic [7:0] WHT = 8'hff;
    localparam logic [7:0] RED = 8'he0;
    localparam logic [7:0] BLU = 8'h03;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_BOUNCE  = 2'd1,
        MODE_SPRITE  = 2'd2,
        MODE_OVERLAY = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_WRAP     = 2'd0,
        ST_BOUNCE_R = 2'd1,
        ST_BOUNCE_L = 2'd2
    } bar_state_e;

endpackage

// File: rtl/tile_renderer_if.sv
// Raster-in / pixel-out bundle between the sync counters, tile memory and DAC registers.
// Streaming, no backpressure: hc/vc advance every clk; addr, color and de follow at fixed latency.
interface tile_renderer_if
    import tile_renderer_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int SPD_W  = 4,
    parameter int POS_W  = 5
) ();

    logic [9:0]        hc;
    logic [9:0]        vc;
    logic              frame_tick;
    logic [1:0]        mode;
    logic [SPD_W-1:0]  speed;
    logic [7:0]        bar_color;
    logic [7:0]        bg_color;
    logic [7:0]        tile_data;
    logic [ADDR_W-1:0] addr;
    logic              de;
    logic [7:0]        color;
    logic [POS_W-1:0]  bar_pos;
    bar_state_e        bar_state;

    modport master (
        output hc, vc, frame_tick, mode, speed, bar_color, bg_color, tile_data,
        input  addr, de, color, bar_pos, bar_state
    );

    modport slave (
        input  hc, vc, frame_tick, mode, speed, bar_color, bg_color, tile_data,
        output addr, de, color, bar_pos, bar_state
    );

endinterface

// File: rtl/tile_axis_counter.sv
// Divider-free pixel-to-tile index: a sub-tile counter that bumps the tile index every TILE steps.
// idx_o is the next-state value, so it is valid for the raster position sampled this clk.
module tile_axis_counter #(
    parameter int TILE = 20,
    parameter int N    = 32,
    localparam int W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         step_i,
    output logic [W-1:0] idx_o
);

    localparam int SW = (TILE > 1) ? $clog2(TILE) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(TILE - 1);

    logic [SW-1:0] sub_q, sub_d;
    logic [W-1:0]  idx_q, idx_d;

    always_comb begin
        sub_d = sub_q;
        idx_d = idx_q;
        if (clear_i) begin
            sub_d = '0;
            idx_d = '0;
        end else if (step_i) begin
            if (sub_q == SUB_LAST) begin
                sub_d = '0;
                idx_d = idx_q + 1'b1;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_q <= '0;
            idx_q <= '0;
        end else begin
            sub_q <= sub_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_d;

endmodule

// File: rtl/tile_renderer.sv
// Tile-grid pixel generator: tile address at +1 clk, colour/de registered at +3 clk,
// with an animated bar column whose motion only changes on frame_tick.
module tile_renderer
    import tile_renderer_pkg::*;
#(
    parameter int         H_ACTIVE    = 640,
    parameter int         V_ACTIVE    = 480,
    parameter int         TILE        = 20,
    parameter int         ADDR_W      = 16,
    parameter int         SPD_W       = 4,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input logic             clk,
    input logic             rst_n,
    tile_renderer_if.slave  bus
);

    localparam int HBLK  = H_ACTIVE / TILE;
    localparam int VBLK  = V_ACTIVE / TILE;
    localparam int POS_W = $clog2(HBLK);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(HBLK - 1);
    localparam logic [POS_W-1:0] POS_PEN  = POS_W'(HBLK - 2);

    logic [$clog2(HBLK)-1:0] tx;
    logic [$clog2(VBLK)-1:0] ty;
    logic                    active;
    logic                    hit;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              act1_q, hit1_q, act2_q, hit2_q;
    logic [7:0]        color_q, color_d;
    logic              de_q;
    logic [7:0]        bar_px;

    bar_state_e        state_q, state_d, eff;
    mode_e             mode_q, mode_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [SPD_W-1:0]  div_q, div_d;
    logic              step_en;

    tile_axis_counter #(.TILE(TILE), .N(HBLK)) u_x (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(bus.hc == 10'd0),
        .step_i (1'b1),
        .idx_o  (tx)
    );

    // Rows move once per line; only the first line of a frame realigns them.
    tile_axis_counter #(.TILE(TILE), .N(VBLK)) u_y (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i((bus.hc == 10'd0) && (bus.vc == 10'd0)),
        .step_i (bus.hc == 10'd0),
        .idx_o  (ty)
    );

    assign active = (int'(bus.hc) < H_ACTIVE) && (int'(bus.vc) < V_ACTIVE);
    assign hit    = (tx == pos_q);
    assign addr_d = active ? ADDR_W'(int'(ty) * HBLK + int'(tx)) : '0;
    assign bar_px = hit2_q ? bus.bar_color : bus.bg_color;

    always_comb begin
        color_d = 8'h00;
        if (act2_q) begin
            case (mode_q)
                MODE_WRAP, MODE_BOUNCE: color_d = bar_px;
                MODE_SPRITE:            color_d = bus.tile_data;
                default:                color_d = (bus.tile_data != TRANSPARENT) ? bus.tile_data : bar_px;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            act1_q  <= 1'b0;
            hit1_q  <= 1'b0;
            act2_q  <= 1'b0;
            hit2_q  <= 1'b0;
            color_q <= 8'h00;
            de_q    <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            act1_q  <= active;
            hit1_q  <= hit;
            act2_q  <= act1_q;
            hit2_q  <= hit1_q;
            color_q <= color_d;
            de_q    <= act2_q;
        end
    end

    // The new mode picks the motion state first; a step in the same tick uses that state.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        div_d   = div_q;
        mode_d  = mode_q;
        eff     = state_q;
        step_en = 1'b0;
        if (bus.frame_tick) begin
            mode_d = mode_e'(bus.mode);
            case (mode_d)
                MODE_BOUNCE: if (state_q == ST_WRAP) eff = (pos_q == POS_LAST) ? ST_BOUNCE_L : ST_BOUNCE_R;
                MODE_SPRITE: eff = state_q;
                default:     eff = ST_WRAP;
            endcase
            state_d = eff;
            if (div_q == bus.speed) begin
                div_d   = '0;
                step_en = 1'b1;
            end else if (div_q > bus.speed) begin
                div_d = '0;
            end else begin
                div_d = div_q + 1'b1;
            end
            if (step_en) begin
                case (eff)
                    ST_WRAP: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
                    ST_BOUNCE_R: begin
                        pos_d = pos_q + 1'b1;
                        if (pos_q == POS_PEN) state_d = ST_BOUNCE_L;
                    end
                    ST_BOUNCE_L: begin
                        pos_d = pos_q - 1'b1;
                        if (pos_q == POS_W'(1)) state_d = ST_BOUNCE_R;
                    end
                    default: state_d = ST_WRAP;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_WRAP;
            mode_q  <= MODE_WRAP;
            pos_q   <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            div_q   <= div_d;
        end
    end

    assign bus.addr      = addr_q;
    assign bus.color     = color_q;
    assign bus.de        = de_q;
    assign bus.bar_pos   = pos_q;
    assign bus.bar_state = state_q;

endmodule
